// File: rtl/ntt_pkg.sv
// Shared widths and types for the NTT datapath (multiplier, Barrett reduction, control).
package ntt_pkg;

  localparam int W_COEF    = 48;
  localparam int W_PROD    = 2 * W_COEF;
  localparam int W_MU      = 53;
  localparam int TAG_W_DEF = 8;

  typedef logic [W_COEF-1:0]    coef_t;
  typedef logic [W_PROD-1:0]    prod_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready skid buffer with registered in_ready and registered head output.
module skid_buf2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          push;
  logic          pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = head;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // in_ready is a flop, so upstream never sees a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
      head     <= '0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (pop) begin
        if (count == 2'd2) head <= tail;
        else if (push)     head <= in_data;
      end else if (push && count == 2'd0) begin
        head <= in_data;
      end
    end
  end

  // NOTE: storage that is only read when marked valid needs no reset; leaving it off frees the reset net.
  always_ff @(posedge clk) begin
    if (push && count == 2'd1 && !pop) tail <= in_data;
  end

endmodule

// File: rtl/int_mult_pipe.sv
// 3-stage pipelined WxW unsigned multiplier built from four (W/2)x(W/2) limb products.
// Define INT_MULT_SKID_EN to place a 2-entry skid buffer at the output with a registered in_ready.
module int_mult_pipe
  import ntt_pkg::*;
#(
  parameter int W     = W_COEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   X,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H  = W / 2;
  localparam int MW = W + 1;
  localparam int PW = 2 * W;

  logic             adv;
  logic             accept;
  logic             s1_v;
  logic             s2_v;
  logic [H-1:0]     a_l, a_h, b_l, b_h;
  logic [TAG_W-1:0] tag1, tag2;
  logic [W-1:0]     p_ll, p_lh, p_hl, p_hh;
  logic [MW-1:0]    mid;
  logic [PW-1:0]    x_next;

  assign accept = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (adv) begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_l  <= a[H-1:0];
      a_h  <= a[W-1:H];
      b_l  <= b[H-1:0];
      b_h  <= b[W-1:H];
      tag1 <= in_tag;
      p_ll <= W'(a_l) * W'(b_l);
      p_lh <= W'(a_l) * W'(b_h);
      p_hl <= W'(a_h) * W'(b_l);
      p_hh <= W'(a_h) * W'(b_h);
      tag2 <= tag1;
    end
  end

  // Cross terms are summed at W+1 bits so their carry reaches bit W+H of the product.
  always_comb begin
    mid    = MW'(p_lh) + MW'(p_hl);
    x_next = {p_hh, p_ll} + (PW'(mid) << H);
  end

`ifdef INT_MULT_SKID_EN
  logic                skid_ready;
  logic [TAG_W+PW-1:0] skid_q;

  // The buffer entries act as stage 3; S1/S2 advance whenever S2 can drain into it.
  assign adv      = ~s2_v | skid_ready;
  assign in_ready = skid_ready;

  skid_buf2 #(
    .DW(TAG_W + PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s2_v),
    .in_ready  (skid_ready),
    .in_data   ({tag2, x_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_q)
  );

  assign {out_tag, X} = skid_q;
`else
  logic s3_v;

  assign adv       = ~s3_v | out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v    <= 1'b0;
      X       <= '0;
      out_tag <= '0;
    end else if (adv) begin
      s3_v    <= s2_v;
      X       <= x_next;
      out_tag <= tag2;
    end
  end
`endif

endmodule

// File: tb/tb_int_mult_pipe.sv
// Directed self-checking bench for int_mult_pipe (base build, with INT_MULT_SKID_EN variants).
module tb_int_mult_pipe;
  import ntt_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  coef_t a;
  coef_t b;
  tag_t  in_tag;
  logic  out_valid;
  logic  out_ready;
  prod_t X;
  tag_t  out_tag;

  int n_cmp = 0;
  int n_err = 0;

`ifdef INT_MULT_SKID_EN
  localparam int FILL_DEPTH = 4;
`else
  localparam int FILL_DEPTH = 3;
`endif

  int_mult_pipe #(.W(48), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic coef_t rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic run_one(input coef_t op_a, input coef_t op_b, input tag_t tg,
                         input prod_t exp_x, input string name);
    int cyc;
    out_ready = 1'b1;
    a = op_a; b = op_b; in_tag = tg; in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 3) begin
      n_err++; $display("FAIL %s_latency: got %0d cycles expected 3", name, cyc);
    end
    n_cmp++;
    if (X !== exp_x) begin
      n_err++; $display("FAIL %s_X: got %h expected %h", name, X, exp_x);
    end
    n_cmp++;
    if (out_tag !== tg) begin
      n_err++; $display("FAIL %s_tag: got %h expected %h", name, out_tag, tg);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL %s_valid_drop: got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (X !== '0) begin n_err++; $display("FAIL reset_X: got %h expected 0", X); end
    n_cmp++;
    if (out_tag !== '0) begin n_err++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    run_one(48'd3, 48'd5, 8'h11, 96'd15, "single");
  endtask

  task automatic test_edge_operands();
    run_one(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 8'h22,
            96'hFFFF_FFFF_FFFE_0000_0000_0001, "max_max");
    run_one(48'h8000_0000_0000, 48'h0000_00FF_FFFF, 8'h33,
            96'h7F_FFFF_8000_0000_0000, "limb_boundary");
    run_one(48'h0, 48'hFFFF_FFFF_FFFF, 8'h44, 96'd0, "zero_a");
    run_one(48'hFFFF_FFFF_FFFF, 48'h0, 8'h45, 96'd0, "zero_b");
    run_one(48'h0000_0100_0000, 48'h0000_0100_0000, 8'h46, 96'h1_0000_0000_0000, "limb_unit");
  endtask

  task automatic test_back_to_back();
    prod_t exp_x [8];
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c <= 10) begin
        n_cmp++;
        if (out_valid !== 1'b1 || X !== exp_x[c-3] || out_tag !== tag_t'(8'hC0 + c - 3)) begin
          n_err++;
          $display("FAIL b2b_out%0d: got v=%b X=%h tag=%h expected v=1 X=%h tag=%h",
                   c - 3, out_valid, X, out_tag, exp_x[c-3], 8'hC0 + c - 3);
        end
      end else if (c == 11) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
      end
      if (c < 8) begin
        a = rand48(); b = rand48(); in_tag = tag_t'(8'hC0 + c); in_valid = 1'b1;
        exp_x[c] = prod_t'(a) * prod_t'(b);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready%0d: got %b expected 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_stream();
    prod_t exp_q [$];
    tag_t  tag_q [$];
    prod_t e_x;
    tag_t  e_t;
    prod_t hold_x;
    tag_t  hold_t;
    logic  hold_pend;
    coef_t cur_a, cur_b;
    int    sent, got, cyc, extra;
    sent = 0; got = 0; cyc = 0; extra = 0; hold_pend = 1'b0;
    cur_a = rand48(); cur_b = rand48();
    while (got < 20 && cyc < 400) begin
      if (hold_pend) begin
        n_cmp++;
        if (out_valid !== 1'b1 || X !== hold_x || out_tag !== hold_t) begin
          n_err++;
          $display("FAIL stream_hold: got v=%b X=%h tag=%h expected v=1 X=%h tag=%h",
                   out_valid, X, out_tag, hold_x, hold_t);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        a = cur_a; b = cur_b; in_tag = tag_t'(8'h40 + sent); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got X=%h tag=%h expected no output", X, out_tag);
        end else begin
          e_x = exp_q.pop_front();
          e_t = tag_q.pop_front();
          if (X !== e_x || out_tag !== e_t) begin
            n_err++;
            $display("FAIL stream_data: got X=%h tag=%h expected X=%h tag=%h", X, out_tag, e_x, e_t);
          end
        end
        got++;
      end
      hold_pend = out_valid & ~out_ready;
      hold_x = X;
      hold_t = out_tag;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(prod_t'(cur_a) * prod_t'(cur_b));
        tag_q.push_back(in_tag);
        sent++;
        cur_a = rand48(); cur_b = rand48();
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (got !== 20 || exp_q.size() != 0) begin
      n_err++; $display("FAIL stream_count: got %0d results expected 20 (pending %0d)", got, exp_q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) extra++;
      tick();
    end
    n_cmp++;
    if (extra !== 0) begin n_err++; $display("FAIL stream_dup: got %0d extra outputs expected 0", extra); end
  endtask

  task automatic test_full_stall();
    prod_t exp_q [$];
    tag_t  tag_q [$];
    prod_t hx;
    prod_t e_x;
    tag_t  e_t;
    int    acc, cyc;
    acc = 0; cyc = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    while (cyc < 20) begin
      a = rand48(); b = rand48(); in_tag = tag_t'(8'h80 + acc);
      #1;
      if (in_ready !== 1'b1) break;
      exp_q.push_back(prod_t'(a) * prod_t'(b));
      tag_q.push_back(in_tag);
      acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc !== FILL_DEPTH) begin n_err++; $display("FAIL stall_fill: got %0d accepted expected %0d", acc, FILL_DEPTH); end
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_ready: got v=%b in_ready=%b expected v=1 in_ready=0", out_valid, in_ready);
    end
    hx = X;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (X !== hx || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got X=%h v=%b rdy=%b expected X=%h v=1 rdy=0", i, X, out_valid, in_ready, hx);
      end
    end
`ifdef INT_MULT_SKID_EN
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_comb: got %b expected 0", in_ready); end
    out_ready = 1'b0;
    tick();
`endif
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (out_valid === 1'b1) begin
        e_x = exp_q.pop_front();
        e_t = tag_q.pop_front();
        n_cmp++;
        if (X !== e_x || out_tag !== e_t) begin
          n_err++; $display("FAIL stall_drain: got X=%h tag=%h expected X=%h tag=%h", X, out_tag, e_x, e_t);
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_empty: got pending=%0d v=%b expected 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand48(); b = rand48(); in_tag = tag_t'(8'hE0 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_inflight: got %b expected 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || X !== '0) begin
      n_err++; $display("FAIL midrst_clear: got v=%b X=%h expected v=0 X=0", out_valid, X);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin n_err++; $display("FAIL midrst_stale: got %0d stale outputs expected 0", stale); end
    run_one(48'h1234_5678_9ABC, 48'h0000_0000_0010, 8'h5A, 96'h1_2345_6789_ABC0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge_operands();
    test_back_to_back();
    test_stream();
    test_full_stall();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_mult_pipe.md
Name: int_mult_pipe

Overview:
- Pipelined 48x48-bit integer multiplier.
- Sits directly upstream of the Barrett reduction stage and produces its 96-bit product input X.
- Moves operand pairs through a 3-stage pipeline with valid/ready flow control and a passthrough tag, so downstream NTT control can match results to coefficient indices.
- Built from four 24x24 limb products so each stage maps onto DSP slices.

Parameters:
- W, 48, operand width; product width is 2*W. Must be even.
- TAG_W, 8, width of the sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present on a/b/in_tag
- in_ready  output  1  block accepts the pair this cycle
- a  input  W  multiplicand, unsigned
- b  input  W  multiplier, unsigned
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  product present on X/out_tag
- out_ready  input  1  downstream accepts the product this cycle
- X  output  2*W  a*b, exact, unsigned
- out_tag  output  TAG_W  tag of the pair that produced X

Behaviour:
- Reset:
  - rst is sampled on the clk rising edge only; one cycle of rst high is sufficient.
  - s1_v, s2_v, s3_v, out_valid reset to 0.
  - X and out_tag reset to 0.
  - in_ready reads 1 the cycle after reset is released.
  - Datapath registers other than X/out_tag need not reset.
- Transfer rule: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Global advance: adv = ~s3_v | out_ready. When adv=1 all stages shift together; when adv=0 all stages hold (no bubble collapse).
- in_ready = adv (combinational from out_ready in the base build).
- Stage S1: capture limbs aL=a[W/2-1:0], aH, bL, bH, in_tag. s1_v <= in_valid.
- Stage S2: four partial products pLL, pLH, pHL, pHH, each W bits. Tag and valid follow.
- Stage S3: X = pHH<<W + (pLH+pHL)<<(W/2) + pLL.
  - Middle sum is W+1 bits; its carry must not be dropped.
  - Final sum is 2*W bits and never overflows.
- Outputs: X/out_tag/out_valid are the S3 registers (registered outputs).
- Latency: an accepted pair appears on out_valid exactly 3 cycles after acceptance when out_ready has been held high.
- Throughput: 1 pair per cycle when out_ready=1.
- Stall behaviour:
  - While out_valid=1 and out_ready=0, X and out_tag are held stable and out_valid stays 1.
  - S1/S2 contents are held and no input is accepted.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both legal. A new product may enter S3 in the same cycle the old one leaves.
- Empty slots: bubbles (in_valid=0) propagate as s*_v=0 and are never presented on out_valid.
- Reset mid-operation: all in-flight pairs are discarded. No out_valid is asserted for them after reset.
- Edge operands: a=0 or b=0 gives X=0; a=b=2^W-1 gives the maximal product.

Optional Feature:
- Macro INT_MULT_SKID_EN.
- Defined:
  - A 2-entry skid buffer is added after S3.
  - in_ready becomes a registered signal = skid buffer not full, with no combinational path from out_ready.
  - Latency 3 cycles with the buffer empty.
  - When the buffer holds 1 entry, new results continue to flow.
  - When it holds 2 entries, in_ready=0.
  - Ordering is preserved; no loss or duplication.
  - Buffer count resets to 0.
- Undefined: base behaviour above, with combinational in_ready = adv.

Decomposition:
- Shared package ntt_pkg:
  - Constants W_COEF=48, W_PROD=96, W_MU=53, TAG_W default.
  - Typedefs coef_t [47:0], prod_t [95:0], tag_t.
- One natural sub-module: skid_buf2, the 2-entry valid/ready skid buffer with data width parameter. It is instantiated only under INT_MULT_SKID_EN and is reusable for the downstream reduction stage.

Test Plan:
- Reset then single pair a=3, b=5, tag=0x11, out_ready=1 -> out_valid exactly 3 cycles after acceptance, X=15, out_tag=0x11, then out_valid=0.
- a=b=0xFFFFFFFFFFFF -> X=0xFFFFFFFFFFFE000000000001; checks the middle-sum carry.
- a=0x800000000000, b=0x000000FFFFFF (limb boundary) and a=0, b=0xFFFFFFFFFFFF -> X=0x7FFFFF800000000000 and X=0 respectively.
- Streaming:
  - Stimulus: 20 back-to-back random pairs, out_ready toggling on a random pattern.
  - Required: every product matches the model, tags stay in order, nothing is lost or duplicated, and X is stable while out_valid & ~out_ready.
  - With out_ready=1 constantly, one result per cycle.
- Full stall: hold out_ready=0 with the pipeline filled -> in_ready=0 (base build) within 0 cycles of S3 filling. Release -> the 3 held results drain in order.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 pairs in flight.
  - Required: out_valid=0 the next cycle; no stale results afterwards; the first post-reset pair appears after exactly 3 cycles.
  - Repeat with INT_MULT_SKID_EN defined, checking that in_ready does not depend on out_ready in the same cycle.
